// File: rtl/popcount_accum.sv
// Frame accumulator for 6-bit popcount beats: sums up to NUM_WORDS beats per frame and holds
// the total on a valid/ready output. Define POPCOUNT_ACCUM_SAT_EN for saturating adds (else wrap).
`default_nettype none

module popcount_accum #(
  parameter int NUM_WORDS = 32,
  parameter int ACC_WIDTH = 11,
  parameter int CNT_WIDTH = $clog2(NUM_WORDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [5:0]           in_count,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [CNT_WIDTH-1:0] out_words,
  output logic                 out_sat
);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [CNT_WIDTH-1:0] words_q, words_d;

  logic                 w_accept;
  logic                 w_close;
  logic [ACC_WIDTH-1:0] w_sum;
  logic [CNT_WIDTH-1:0] w_cnt_inc;

  // acc_q/cnt_q are already zero while holding, so a beat accepted in HOLD starts a fresh frame
  assign in_ready  = (state_q == ST_ACCUM) | out_ready;
  assign out_valid = (state_q == ST_HOLD);
  assign w_accept  = in_valid & in_ready;
  assign w_close   = in_last | (cnt_q == CNT_WIDTH'(NUM_WORDS - 1));
  assign w_cnt_inc = cnt_q + CNT_WIDTH'(1);

`ifdef POPCOUNT_ACCUM_SAT_EN
  logic                 sat_q, sat_d;
  logic                 osat_q, osat_d;
  logic [ACC_WIDTH:0]   w_wide;
  logic                 w_sat_hit;

  assign w_wide    = {1'b0, acc_q} + (ACC_WIDTH + 1)'(in_count);
  assign w_sat_hit = sat_q | w_wide[ACC_WIDTH];
  assign w_sum     = w_sat_hit ? {ACC_WIDTH{1'b1}} : w_wide[ACC_WIDTH-1:0];
  assign out_sat   = osat_q;
`else
  assign w_sum     = acc_q + ACC_WIDTH'(in_count);
  assign out_sat   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    words_d = words_q;
`ifdef POPCOUNT_ACCUM_SAT_EN
    sat_d   = sat_q;
    osat_d  = osat_q;
`endif
    if (w_accept) begin
      if (w_close) begin
        sum_d   = w_sum;
        words_d = w_cnt_inc;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ST_HOLD;
`ifdef POPCOUNT_ACCUM_SAT_EN
        osat_d  = w_sat_hit;
        sat_d   = 1'b0;
`endif
      end else begin
        acc_d   = w_sum;
        cnt_d   = w_cnt_inc;
        state_d = ST_ACCUM;
`ifdef POPCOUNT_ACCUM_SAT_EN
        sat_d   = w_sat_hit;
`endif
      end
    end else if ((state_q == ST_HOLD) && out_ready) begin
      state_d = ST_ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      words_q <= '0;
`ifdef POPCOUNT_ACCUM_SAT_EN
      sat_q   <= 1'b0;
      osat_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      words_q <= words_d;
`ifdef POPCOUNT_ACCUM_SAT_EN
      sat_q   <= sat_d;
      osat_q  <= osat_d;
`endif
    end
  end

  assign out_sum   = sum_q;
  assign out_words = words_q;

endmodule

`default_nettype wire

// File: tb/tb_popcount_accum.sv
// Bench for popcount_accum: two instances (ACC_WIDTH 8 and 6, NUM_WORDS 4) share one stimulus
// stream and are checked every cycle against a frame-level model, plus literal spot checks.
`default_nettype none

module tb_popcount_accum;

  localparam int NW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [5:0] in_count = '0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;

  logic       in_ready_a, out_valid_a, out_sat_a;
  logic [7:0] out_sum_a;
  logic [2:0] out_words_a;
  logic       in_ready_b, out_valid_b, out_sat_b;
  logic [5:0] out_sum_b;
  logic [2:0] out_words_b;

  popcount_accum #(.NUM_WORDS(NW), .ACC_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_count(in_count), .in_last(in_last), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_sum(out_sum_a), .out_words(out_words_a),
    .out_sat(out_sat_a)
  );

  popcount_accum #(.NUM_WORDS(NW), .ACC_WIDTH(6)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_count(in_count), .in_last(in_last), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_sum(out_sum_b), .out_words(out_words_b),
    .out_sat(out_sat_b)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: current frame as a queue, last completed result as its exact total
  bit exp_valid = 1'b0;
  int exp_full  = 0;
  int exp_words = 0;
  int frame[$];

  function automatic int ex_sum(input int full, input int w);
    int mx;
    mx = (1 << w) - 1;
`ifdef POPCOUNT_ACCUM_SAT_EN
    return (full > mx) ? mx : full;
`else
    return full % (mx + 1);
`endif
  endfunction

  function automatic int ex_sat(input int full, input int w);
`ifdef POPCOUNT_ACCUM_SAT_EN
    return (full > (1 << w) - 1) ? 1 : 0;
`else
    return (full < 0 || w < 0) ? 1 : 0;
`endif
  endfunction

  always @(negedge clk) begin
    int  s;
    bit  exp_rdy;
    exp_rdy = !exp_valid || out_ready;
    if (checking) begin
      chk("valid_a", int'(out_valid_a), int'(exp_valid));
      chk("valid_b", int'(out_valid_b), int'(exp_valid));
      chk("ready_a", int'(in_ready_a), int'(exp_rdy));
      chk("ready_b", int'(in_ready_b), int'(exp_rdy));
      chk("sum_a", int'(out_sum_a), ex_sum(exp_full, 8));
      chk("sum_b", int'(out_sum_b), ex_sum(exp_full, 6));
      chk("words_a", int'(out_words_a), exp_words);
      chk("words_b", int'(out_words_b), exp_words);
      chk("sat_a", int'(out_sat_a), ex_sat(exp_full, 8));
      chk("sat_b", int'(out_sat_b), ex_sat(exp_full, 6));
    end
    if (rst) begin
      exp_valid = 1'b0;
      exp_full  = 0;
      exp_words = 0;
      frame.delete();
    end else begin
      if (exp_valid && out_ready) exp_valid = 1'b0;
      if (in_valid && exp_rdy) begin
        frame.push_back(int'(in_count));
        if (in_last || frame.size() == NW) begin
          s = 0;
          foreach (frame[i]) s += frame[i];
          exp_full  = s;
          exp_words = frame.size();
          exp_valid = 1'b1;
          frame.delete();
        end
      end
    end
  end

  task automatic beat(input int c, input bit l);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_count = 6'(c);
    in_last  = l;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = in_ready_a;
      @(posedge clk);
      #1;
    end
    if (!done) chk("beat_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    checking = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", int'(out_valid_a), 0);
    chk("rst_sum", int'(out_sum_a), 0);
    chk("rst_words", int'(out_words_a), 0);

    // full-length frame closes on count alone
    beat(32, 0); beat(32, 0); beat(32, 0); beat(32, 0);
    chk("t1_sum", int'(out_sum_a), 128);
    chk("t1_words", int'(out_words_a), 4);
    idle(2);

    beat(5, 0); beat(7, 1);
    chk("t2_sum", int'(out_sum_a), 12);
    chk("t2_words", int'(out_words_a), 2);
    beat(9, 1);
    chk("t2b_sum", int'(out_sum_a), 9);
    chk("t2b_words", int'(out_words_a), 1);
    idle(2);

    // back-pressure while holding a result
    out_ready = 1'b0;
    beat(4, 1);
    in_valid = 1'b1; in_count = 6'd3; in_last = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t3_ready", int'(in_ready_a), 0);
      chk("t3_sum", int'(out_sum_a), 4);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    beat(3, 0);
    chk("t3_taken", int'(out_valid_a), 0);
    beat(2, 1);
    chk("t3_sum2", int'(out_sum_a), 5);
    chk("t3_words2", int'(out_words_a), 2);
    idle(2);

    beat(1, 1); chk("t4_s1", int'(out_sum_a), 1);
    beat(2, 1); chk("t4_s2", int'(out_sum_a), 2);
    beat(4, 1); chk("t4_s4", int'(out_sum_a), 4);
    idle(2);

    // reset mid-frame discards the partial sum
    beat(10, 0); beat(10, 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("t5_rst_valid", int'(out_valid_a), 0);
    beat(6, 1);
    chk("t5_sum", int'(out_sum_a), 6);
    chk("t5_words", int'(out_words_a), 1);
    idle(2);

    // in_last on the NUM_WORDS-th beat closes exactly one frame
    beat(1, 0); beat(1, 0); beat(1, 0); beat(1, 1);
    chk("tn_words", int'(out_words_a), 4);
    beat(2, 1);
    chk("tn_sum", int'(out_sum_a), 2);
    chk("tn_words2", int'(out_words_a), 1);
    idle(2);

    beat(32, 0); beat(32, 1);
    chk("t6_sum_a", int'(out_sum_a), 64);
`ifdef POPCOUNT_ACCUM_SAT_EN
    chk("t6_sum_b", int'(out_sum_b), 63);
    chk("t6_sat_b", int'(out_sat_b), 1);
`else
    chk("t6_sum_b", int'(out_sum_b), 0);
    chk("t6_sat_b", int'(out_sat_b), 0);
`endif
    beat(1, 1);
    chk("t6_sum_b2", int'(out_sum_b), 1);
    chk("t6_sat_b2", int'(out_sat_b), 0);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_count  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(33, 63))
                                               : 6'($urandom_range(0, 32));
      in_last   = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
